// File: rtl/spram_fifo_pkg.sv
// Shared types for spram_fifo.
// entry_t/word_t describe the default-width entry and the two-entry RAM word
// (element 0 is the older entry). ram_op_e names the single RAM access the
// arbiter may issue per cycle.
package spram_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef logic [DATA_WIDTH_DEF-1:0] entry_t;
  typedef entry_t [1:0]              word_t;

  typedef enum logic [1:0] {
    RAM_IDLE,
    RAM_RD,
    RAM_WR
  } ram_op_e;

  // Two entries per RAM word.
  function automatic int unsigned ram_words(input int unsigned depth);
    return depth / 2;
  endfunction

endpackage

// File: rtl/spram_fifo_ram.sv
// Behavioural single-port RAM: one access per cycle, 1-cycle read latency.
// Ports: clk, en (access strobe), we (1=write, 0=read), addr, din, dout
// (registered read data, held until the next read).
module spram_fifo_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/spram_fifo.sv
// Synchronous FIFO whose bulk storage is a single-port RAM holding two
// entries per word, so sustained simultaneous read+write at one entry/cycle
// each needs the RAM only every other cycle per side.
// Ports: clk, rst_n (async, active-low); ren/rdata (registered)/empty;
// wen/wdata/full; count = occupancy modulo FIFO_DEPTH.
// Define SPRAM_FIFO_ASSERT_EN to compile in SVA protocol/consistency checks.
//
// Logical entry order, oldest first:
//   rs (read-side buffer: 2-entry unpack + 1 prefetched word, 0..4 entries)
//   -> RAM word in flight -> RAM -> pending write word -> pack register.
module spram_fifo
  import spram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam int unsigned WORDS = ram_words(FIFO_DEPTH);
  localparam int unsigned WAW   = ADDR_WIDTH - 1;

  typedef logic [DATA_WIDTH-1:0]      data_t;
  typedef logic [1:0][DATA_WIDTH-1:0] pair_t;
  typedef logic [3:0][DATA_WIDTH-1:0] rsbuf_t;

  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic                  full_q, full_d, empty_q, empty_d;
  data_t                 rdata_q, rdata_d;
  rsbuf_t                rs_q, rs_d;
  logic [2:0]            rs_cnt_q, rs_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] ram_words_q, ram_words_d;
  logic [WAW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  pair_t                 pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  data_t                 pack_q, pack_d;
  logic                  pack_vld_q, pack_vld_d;

  logic                  wr_acc, rd_acc, dout_taken, rd_issue, wr_issue;
  ram_op_e               ram_op;
  logic [WAW-1:0]        ram_addr;
  pair_t                 ram_din, ram_dout;

  // Append a word at position 'at' of the read-side buffer.
  function automatic rsbuf_t put_pair(input rsbuf_t rb_in, input logic [2:0] at,
                                      input pair_t w);
    rsbuf_t rb;
    rb = rb_in;
    case (at)
      3'd0:    rb[1:0] = w;
      3'd1:    rb[2:1] = w;
      default: rb[3:2] = w;
    endcase
    return rb;
  endfunction

  always_comb begin
    wr_acc      = wen & ~full_q;
    rd_acc      = ren & ~empty_q;
    rdata_d     = rdata_q;
    rs_d        = rs_q;
    rs_cnt_d    = rs_cnt_q;
    inflight_d  = 1'b0;
    ram_words_d = ram_words_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    pack_d      = pack_q;
    pack_vld_d  = pack_vld_q;
    dout_taken  = 1'b0;
    rd_issue    = 1'b0;
    wr_issue    = 1'b0;
    ram_addr    = rd_ptr_q;
    ram_din     = pend_q;

    // Pop the oldest entry. The arbiter keeps rs or the in-flight word
    // non-empty whenever RAM holds words, so the head is never inside RAM.
    if (rd_acc) begin
      if (rs_cnt_q != 3'd0) begin
        rdata_d  = rs_q[0];
        rs_d     = rs_q >> DATA_WIDTH;
        rs_cnt_d = rs_cnt_q - 3'd1;
      end else if (inflight_q) begin
        rdata_d    = ram_dout[0];
        rs_d[0]    = ram_dout[1];
        rs_cnt_d   = 3'd1;
        dout_taken = 1'b1;
      end else if (pend_vld_q) begin
        rdata_d    = pend_q[0];
        rs_d[0]    = pend_q[1];
        rs_cnt_d   = 3'd1;
        pend_vld_d = 1'b0;
      end else begin
        rdata_d    = pack_q;
        pack_vld_d = 1'b0;
      end
    end

    if (inflight_q && !dout_taken) begin
      rs_d     = put_pair(rs_d, rs_cnt_d, ram_dout);
      rs_cnt_d = rs_cnt_d + 3'd2;
    end

    // One RAM op per cycle. A refill at <=1 buffered entry always leaves >=2
    // next cycle, so the pending word is never held off twice in a row.
    if ((ram_words_q != '0) && (rs_cnt_d <= 3'd1)) begin
      rd_issue = 1'b1;
    end else if (pend_vld_d && (ram_words_q == '0) && !inflight_q && (rs_cnt_d <= 3'd2)) begin
      rs_d       = put_pair(rs_d, rs_cnt_d, pend_q);
      rs_cnt_d   = rs_cnt_d + 3'd2;
      pend_vld_d = 1'b0;
    end else if (pend_vld_d) begin
      wr_issue = 1'b1;
    end else if ((ram_words_q != '0) && (rs_cnt_d <= 3'd2)) begin
      rd_issue = 1'b1;
    end

    if (rd_issue) begin
      ram_addr    = rd_ptr_q;
      rd_ptr_d    = rd_ptr_q + WAW'(1);
      ram_words_d = ram_words_q - ADDR_WIDTH'(1);
      inflight_d  = 1'b1;
    end
    if (wr_issue) begin
      ram_addr    = wr_ptr_q;
      wr_ptr_d    = wr_ptr_q + WAW'(1);
      ram_words_d = ram_words_q + ADDR_WIDTH'(1);
      pend_vld_d  = 1'b0;
    end

    if (wr_acc) begin
      if (pack_vld_d) begin
        pend_d     = {wdata, pack_q};
        pend_vld_d = 1'b1;
        pack_vld_d = 1'b0;
      end else begin
        pack_d     = wdata;
        pack_vld_d = 1'b1;
      end
    end

    case ({wr_acc, rd_acc})
      2'b10:   occ_d = occ_q + (ADDR_WIDTH+1)'(1);
      2'b01:   occ_d = occ_q - (ADDR_WIDTH+1)'(1);
      default: occ_d = occ_q;
    endcase
    full_d  = (occ_d == (ADDR_WIDTH+1)'(FIFO_DEPTH));
    empty_d = (occ_d == '0);

    ram_op = wr_issue ? RAM_WR : (rd_issue ? RAM_RD : RAM_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rdata_q     <= '0;
      rs_q        <= '0;
      rs_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      ram_words_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      pack_q      <= '0;
      pack_vld_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rdata_q     <= rdata_d;
      rs_q        <= rs_d;
      rs_cnt_q    <= rs_cnt_d;
      inflight_q  <= inflight_d;
      ram_words_q <= ram_words_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      pack_q      <= pack_d;
      pack_vld_q  <= pack_vld_d;
    end
  end

  spram_fifo_ram #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (WORDS),
    .AW    (WAW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_op != RAM_IDLE),
    .we   (ram_op == RAM_WR),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign rdata = rdata_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = occ_q[ADDR_WIDTH-1:0];

`ifdef SPRAM_FIFO_ASSERT_EN
  a_wr_full: assert property (@(posedge clk) disable iff (!rst_n) !(wen && full_q))
    else $error("spram_fifo: write while full");
  a_rd_empty: assert property (@(posedge clk) disable iff (!rst_n) !(ren && empty_q))
    else $error("spram_fifo: read while empty");
  a_occ: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= (ADDR_WIDTH+1)'(FIFO_DEPTH))
    else $error("spram_fifo: occupancy above depth");
  a_one_op: assert property (@(posedge clk) disable iff (!rst_n) !(rd_issue && wr_issue))
    else $error("spram_fifo: two RAM ops in one cycle");
  a_wdata_x: assert property (@(posedge clk) disable iff (!rst_n) !(wr_acc && $isunknown(wdata)))
    else $error("spram_fifo: X on wdata for accepted write");
  a_head: assert property (@(posedge clk) disable iff (!rst_n)
                           !((ram_words_q != '0) && (rs_cnt_q == 3'd0) && !inflight_q))
    else $error("spram_fifo: head entry left in RAM");
`endif

endmodule

// File: tb/tb_spram_fifo.sv
// Directed/random bench for spram_fifo with a queue scoreboard: accepted
// writes are pushed, accepted reads pop the expected rdata.
module tb_spram_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n, ren, wen;
  logic [DW-1:0] wdata, rdata;
  logic          empty, full;
  logic [AW-1:0] count;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_rdata = '0;

  always #5 clk = ~clk;

  spram_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ren   (ren),
    .rdata (rdata),
    .empty (empty),
    .wen   (wen),
    .wdata (wdata),
    .full  (full),
    .count (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(sb.size() % DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
    chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rdata));
  endtask

  // One clock: drive, update scoreboard from pre-cycle occupancy, check after edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
    logic acc_w, acc_r;
    acc_w = w && (sb.size() < DEPTH);
    acc_r = r && (sb.size() != 0);
    wen   = w;
    wdata = d;
    ren   = r;
    if (acc_r) exp_rdata = sb.pop_front();
    if (acc_w) sb.push_back(d);
    @(posedge clk);
    #1;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = '0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    #1;
    sb.delete();
    exp_rdata = '0;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = '0;

    // 1: reset and idle
    do_reset("t1.rst");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "t1.idle");

    // 2: three writes then held reads, plus one read on empty (rdata holds)
    step(1'b1, 8'd10, 1'b0, "t2.wr");
    step(1'b1, 8'd11, 1'b0, "t2.wr");
    step(1'b1, 8'd12, 1'b0, "t2.wr");
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "t2.rd");

    // 3: prefill 3 then simultaneous read+write, then drain
    step(1'b1, 8'd10, 1'b0, "t3.wr");
    step(1'b1, 8'd11, 1'b0, "t3.wr");
    step(1'b1, 8'd12, 1'b0, "t3.wr");
    step(1'b1, 8'd13, 1'b1, "t3.rw");
    step(1'b1, 8'd14, 1'b1, "t3.rw");
    step(1'b1, 8'd65, 1'b1, "t3.rw");
    step(1'b1, 8'd22, 1'b1, "t3.rw");
    step(1'b1, 8'd13, 1'b1, "t3.rw");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "t3.drain");

    // Simultaneous read+write on empty: write accepted, read ignored
    step(1'b1, 8'h5A, 1'b1, "t3.rw_empty");
    step(1'b0, '0, 1'b1, "t3.rd_empty");

    // 4: fill to full, dropped write, read+write at full, drain in order
    for (int i = 0; i < 32; i++) step(1'b1, 8'(8'h80 + i), 1'b0, "t4.fill");
    step(1'b1, 8'hEE, 1'b0, "t4.wr_full");
    step(1'b1, 8'hEF, 1'b1, "t4.rw_full");
    for (int i = 0; i < 33; i++) step(1'b0, '0, 1'b1, "t4.drain");

    // 5: fill to 31, alternate reads/writes across pointer wrap, random mix
    for (int i = 0; i < 31; i++) step(1'b1, 8'(i), 1'b0, "t5.fill");
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) step(1'b0, '0, 1'b1, "t5.alt_rd");
      else            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, "t5.alt_wr");
    end
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "t5.rand");
    for (int i = 0; i < 34; i++) step(1'b0, '0, 1'b1, "t5.drain");

    // 6: reset with 7 entries stored; old data must not reappear
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, "t6.fill");
    do_reset("t6.rst");
    step(1'b1, 8'h31, 1'b0, "t6.wr");
    step(1'b1, 8'h32, 1'b0, "t6.wr");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "t6.rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
